// File: rtl/alu_pkg.sv
// alu_pkg: control-word bit positions shared by the ALU datapath and its sequencer
package alu_pkg;
  localparam int CTRL_W = 15;
  localparam int C_LD_ADD = 0;
  localparam int C_LD_MUL = 1;
  localparam int C_LD_DIV = 2;
  localparam int C_DEC = 3;
  localparam int C_ADD = 4;
  localparam int C_SUB = 5;
  localparam int C_QBIT = 6;
  localparam int C_CNT_A = 7;
  localparam int C_ASR = 8;
  localparam int C_LSH = 9;
  localparam int C_CNT_B = 10;
  localparam int C_CORR = 11;
  localparam int C_OUT_A = 12;
  localparam int C_OUT_AQ = 13;
  localparam int C_OUT_Q = 14;
endpackage

// File: rtl/add_sub_unit.sv
// add_sub_unit: combinational W-bit adder/subtractor (two's complement, modulo 2^W)
module add_sub_unit #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);
  assign sum = a + (sub ? ~b : b) + {{(W-1){1'b0}}, sub};
endmodule

// File: rtl/alu_datapath.sv
// alu_datapath: A/Q/M register datapath for add, subtract, Booth multiply and
// non-restoring divide, steered by a one-hot control word from the sequencer
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CTRL_W-1:0]    c,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 q_0,
  output logic                 q_min1,
  output logic                 sign,
  output logic                 cnt7,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid
);
  logic [WIDTH:0] acc, acc_n, m_ext, sum;
  logic [WIDTH-1:0] q, q_n, m, m_n;
  logic qm1, qm1_n, ld, sub;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2*WIDTH-1:0] out_n;
  assign m_ext = {m[WIDTH-1], m};
  // the correction add (c[11]) never subtracts
  assign sub = c[C_ADD] & c[C_SUB];
  add_sub_unit #(.W(WIDTH + 1)) u_add (
    .a(acc),
    .b(m_ext),
    .sub(sub),
    .sum(sum)
  );
  assign ld = c[C_LD_ADD] | c[C_LD_MUL] | c[C_LD_DIV];
  assign q_0 = q[0];
  assign q_min1 = qm1;
  assign sign = acc[WIDTH];
  assign cnt7 = cnt == CNT_W'(WIDTH - 1);
  always_comb begin
    acc_n = c[C_LD_ADD] ? {x[WIDTH-1], x}
          : (c[C_LD_MUL] | c[C_LD_DIV]) ? '0
          : (c[C_ADD] | c[C_CORR]) ? sum
          : c[C_ASR] ? {acc[WIDTH], acc[WIDTH:1]}
          : c[C_LSH] ? {acc[WIDTH-1:0], q[WIDTH-1]}
          : acc;
    q_n = c[C_LD_ADD] ? '0
        : ld ? x
        : c[C_ASR] ? {acc[0], q[WIDTH-1:1]}
        : c[C_LSH] ? {q[WIDTH-2:0], 1'b0}
        : c[C_QBIT] ? {q[WIDTH-1:1], ~acc[WIDTH]}
        : q;
    m_n = ld ? y : m;
    qm1_n = ld ? 1'b0 : c[C_ASR] ? q[0] : qm1;
    cnt_n = ld ? '0
          : (c[C_CNT_A] | c[C_CNT_B]) ? (cnt7 ? '0 : cnt + CNT_W'(1))
          : cnt;
    out_n = c[C_OUT_A] ? {{WIDTH{acc[WIDTH-1]}}, acc[WIDTH-1:0]}
          : c[C_OUT_AQ] ? {acc[WIDTH-1:0], q}
          : c[C_OUT_Q] ? {out[WIDTH-1:0], q}
          : out;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      q <= '0;
      m <= '0;
      qm1 <= 1'b0;
      cnt <= '0;
      out <= '0;
      out_valid <= 1'b0;
    end else begin
      acc <= acc_n;
      q <= q_n;
      m <= m_n;
      qm1 <= qm1_n;
      cnt <= cnt_n;
      out <= out_n;
      out_valid <= c[C_OUT_A] | c[C_OUT_AQ] | c[C_OUT_Q];
    end
  end
endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: directed scenarios with a scoreboard of expected results
module tb_alu_datapath;
  import alu_pkg::*;
  logic clk = 0, rst_n = 0;
  logic [CTRL_W-1:0] c = '0;
  logic [7:0] x = '0, y = '0;
  logic q_0, q_min1, sign, cnt7, out_valid;
  logic [15:0] out;
  int checks = 0, errors = 0, pulses = 0;
  logic [15:0] sb[$];
  alu_datapath dut (
    .clk(clk), .rst_n(rst_n), .c(c), .x(x), .y(y),
    .q_0(q_0), .q_min1(q_min1), .sign(sign), .cnt7(cnt7),
    .out(out), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (out_valid) begin
    logic [15:0] e;
    pulses++;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: unexpected out_valid, out=%h", out);
    end else begin
      e = sb.pop_front();
      if (out !== e) begin
        errors++;
        $display("FAIL scoreboard: out=%h expected %h", out, e);
      end
    end
  end
  function automatic logic [14:0] bit_of(input int i);
    return 15'(1) << i;
  endfunction
  task automatic cyc(input logic [14:0] cc);
    c = cc;
    @(posedge clk);
    #1 c = '0;
  endtask
  task automatic test_reset;
    #12;
    checks++;
    if ({dut.acc, dut.q, dut.m, dut.cnt, out, out_valid, cnt7} !== '0) begin
      errors++;
      $display("FAIL reset_state: regs not zero, out=%h cnt7=%b", out, cnt7);
    end
    rst_n = 1;
    cyc('0);
  endtask
  task automatic test_add;
    x = 8'd25; y = 8'd17;
    cyc(bit_of(C_LD_ADD));
    cyc(bit_of(C_ADD));
    checks++;
    if (dut.acc !== 9'h02A || sign !== 1'b0) begin
      errors++;
      $display("FAIL add_acc: acc=%h sign=%b expected 02a 0", dut.acc, sign);
    end
    sb.push_back(16'h002A);
    cyc(bit_of(C_OUT_A));
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h002A) begin
      errors++;
      $display("FAIL add_out: out=%h valid=%b expected 002a 1", out, out_valid);
    end
    cyc('0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_valid_pulse: valid=%b expected 0", out_valid);
    end
  endtask
  task automatic test_sub;
    x = 8'd5; y = 8'd9;
    cyc(bit_of(C_LD_ADD));
    cyc(bit_of(C_ADD) | bit_of(C_SUB));
    checks++;
    if (dut.acc !== 9'h1FC || sign !== 1'b1) begin
      errors++;
      $display("FAIL sub_acc: acc=%h sign=%b expected 1fc 1", dut.acc, sign);
    end
    sb.push_back(16'hFFFC);
    cyc(bit_of(C_OUT_A));
    cyc('0);
  endtask
  task automatic test_booth;
    x = 8'd3; y = 8'd5;
    cyc(bit_of(C_LD_MUL));
    checks++;
    if (q_0 !== 1'b1 || q_min1 !== 1'b0 || dut.acc !== 9'h000) begin
      errors++;
      $display("FAIL booth_load: q_0=%b q_min1=%b acc=%h expected 1 0 000", q_0, q_min1, dut.acc);
    end
    cyc(bit_of(C_ADD) | bit_of(C_SUB));
    checks++;
    if (dut.acc !== 9'h1FB) begin
      errors++;
      $display("FAIL booth_sub: acc=%h expected 1fb", dut.acc);
    end
    cyc(bit_of(C_ASR));
    checks++;
    if (dut.acc !== 9'h1FD || dut.q !== 8'h81 || q_min1 !== 1'b1) begin
      errors++;
      $display("FAIL booth_asr: acc=%h q=%h q_min1=%b expected 1fd 81 1", dut.acc, dut.q, q_min1);
    end
    sb.push_back(16'hFD81);
    cyc(bit_of(C_OUT_AQ));
    cyc('0);
  endtask
  task automatic test_counter;
    cyc(bit_of(C_LD_MUL));
    checks++;
    if (cnt7 !== 1'b0) begin
      errors++;
      $display("FAIL cnt_load: cnt7=%b expected 0", cnt7);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(bit_of(i % 2 ? C_CNT_A : C_CNT_B));
      checks++;
      if (cnt7 !== (i == 6)) begin
        errors++;
        $display("FAIL cnt_pulse%0d: cnt7=%b expected %b", i + 1, cnt7, i == 6);
      end
    end
  endtask
  task automatic test_div;
    int p0;
    x = 8'd100; y = 8'd7;
    cyc(bit_of(C_LD_DIV));
    cyc(bit_of(C_LSH));
    checks++;
    if (dut.acc !== 9'h000 || dut.q !== 8'hC8) begin
      errors++;
      $display("FAIL div_lsh: acc=%h q=%h expected 000 c8", dut.acc, dut.q);
    end
    cyc(bit_of(C_ADD) | bit_of(C_SUB));
    checks++;
    if (dut.acc !== 9'h1F9 || sign !== 1'b1) begin
      errors++;
      $display("FAIL div_sub: acc=%h sign=%b expected 1f9 1", dut.acc, sign);
    end
    cyc(bit_of(C_QBIT));
    checks++;
    if (dut.q !== 8'hC8) begin
      errors++;
      $display("FAIL div_qbit: q=%h expected c8", dut.q);
    end
    cyc(bit_of(C_CORR));
    checks++;
    if (dut.acc !== 9'h000) begin
      errors++;
      $display("FAIL div_corr: acc=%h expected 000", dut.acc);
    end
    p0 = pulses;
    sb.push_back(16'h0000);
    cyc(bit_of(C_OUT_A));
    sb.push_back(16'h00C8);
    cyc(bit_of(C_OUT_Q));
    cyc('0);
    checks++;
    if (out !== 16'h00C8 || pulses - p0 != 2) begin
      errors++;
      $display("FAIL div_out: out=%h pulses=%0d expected 00c8 2", out, pulses - p0);
    end
  endtask
  task automatic test_qbit_set;
    x = 8'd10; y = 8'd3;
    cyc(bit_of(C_LD_DIV));
    cyc(bit_of(C_QBIT));
    checks++;
    if (dut.q !== 8'h0B) begin
      errors++;
      $display("FAIL qbit_set: q=%h expected 0b", dut.q);
    end
  endtask
  task automatic test_async_reset;
    x = 8'hFF; y = 8'h11;
    cyc(bit_of(C_LD_MUL));
    #2 rst_n = 0;
    #1;
    checks++;
    if ({dut.acc, dut.q, dut.m, dut.cnt, out, out_valid, cnt7} !== '0) begin
      errors++;
      $display("FAIL async_reset: q=%h m=%h out=%h valid=%b", dut.q, dut.m, out, out_valid);
    end
    #3 rst_n = 1;
    cyc('0);
    checks++;
    if ({dut.acc, dut.q, dut.m, dut.cnt, out, out_valid} !== '0) begin
      errors++;
      $display("FAIL post_reset: q=%h m=%h out=%h valid=%b", dut.q, dut.m, out, out_valid);
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub;
    test_booth;
    test_counter;
    test_div;
    test_qbit_set;
    test_async_reset;
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never produced, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
